// File: rtl/crc_byte_serializer.sv
// rtl/crc_byte_serializer.sv - byte-to-serial feeder for the serial CRC-8 generator
module crc_byte_serializer #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 8,
    parameter int LSB_FIRST  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_data,
    output logic              ser_active,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [7:0]       LAST_GAP = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               ser_data_q, ser_data_d;
    logic               ser_active_q, ser_active_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic               accept;
    logic               head_bit;

    assign in_ready   = !hold_full_q;
    assign ser_data   = ser_data_q;
    assign ser_active = ser_active_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        accept       = in_valid && !hold_full_q;
        head_bit     = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_W-1];

        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d     = SHIFT;
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                end
            end
            SHIFT: begin
                shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    bit_cnt_d = '0;
                    // A byte arriving on this very edge bypasses the holding register
                    if (hold_full_q) begin
                        state_d     = SHIFT;
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        state_d     = SHIFT;
                        shift_d     = in_data;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the current state, so they trail it by one cycle
        ser_active_d = (state_q == SHIFT);
        ser_data_d   = (state_q == SHIFT) ? head_bit : 1'b0;
        frame_done_d = (state_q == GAP) && (gap_cnt_q == LAST_GAP);
        busy_d       = (state_q != IDLE) || hold_full_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            ser_data_q   <= 1'b0;
            ser_active_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            ser_data_q   <= ser_data_d;
            ser_active_q <= ser_active_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: doc/crc_byte_serializer.md
Name: crc_byte_serializer

Overview:
Upstream feeder for the serial CRC-8 generator. Accepts parallel bytes over a valid/ready handshake and drives the generator's serial `data`/`active` inputs: exactly DATA_W consecutive active cycles per byte, then GAP_CYCLES inactive cycles during which the generator drains its CRC. A one-entry holding register allows the next byte to be accepted while the current byte is shifting or draining, so frames go out back-to-back with no extra idle cycles.

Parameters:
DATA_W, 8, bits per frame; must equal the CRC generator's bit count per frame.
GAP_CYCLES, 8, inactive cycles after each frame (CRC drain window); legal range 8..255.
LSB_FIRST, 1, 1 = bit 0 shifted first, 0 = bit DATA_W-1 shifted first.

Ports:
clk  input  1  rising-edge clock, shared with the CRC generator
reset  input  1  synchronous, active-high reset
in_data  input  DATA_W  byte to serialize; sampled when in_valid && in_ready
in_valid  input  1  upstream has a byte
in_ready  output  1  holding register empty; byte accepted on the edge where in_valid && in_ready
ser_data  output  1  serial bit to the CRC generator `data` input
ser_active  output  1  to the CRC generator `active` input; high for exactly DATA_W cycles per frame
busy  output  1  state != IDLE or holding register full
frame_done  output  1  one-cycle pulse on the last GAP cycle of each frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset). All outputs are registered except in_ready, which is defined as !hold_full.
- Reset (sampled on a clk edge): state=IDLE, hold_full=0, bit_cnt=0, gap_cnt=0, ser_data=0, ser_active=0, frame_done=0, busy=0, in_ready=1. Reset mid-frame aborts the frame immediately. The held byte is discarded. Downstream must be reset in the same cycle.
- State machine: IDLE, SHIFT, GAP.
- Holding register load: hold_full sets on the accepting edge.
- IDLE:
  - If hold_full, go to SHIFT next edge: load shift_reg from hold, clear hold_full, bit_cnt=0.
  - An accept in IDLE therefore produces the first ser_active=1 cycle two edges later (latency 2).
- SHIFT:
  - ser_active=1; ser_data=shift_reg[0] (LSB_FIRST) or shift_reg[DATA_W-1].
  - Shift by one bit per cycle.
  - After DATA_W cycles, go to GAP with gap_cnt=0; no early exit.
- GAP:
  - ser_active=0, ser_data=0.
  - On gap_cnt==GAP_CYCLES-1: frame_done=1 for that cycle.
  - Next state is SHIFT, loading from hold and clearing hold_full, if hold_full (including a byte accepted on this same edge: accept and load coincide, hold bypass allowed). Otherwise next state is IDLE.
- Back-to-back frames: ser_active pattern is exactly DATA_W high, GAP_CYCLES low, DATA_W high, with no extra idle cycle.
- Holding register accept: in_ready is high in any state while hold is empty.
  - A byte accepted during SHIFT or GAP waits in hold.
  - A second byte stalls, with in_ready=0, until hold is transferred to shift_reg.
- in_data is don't-care when in_valid=0. Upstream must hold in_data stable while in_valid && !in_ready.
- ser_active never glitches high in GAP/IDLE; the count of high cycles per frame is exactly DATA_W, which the CRC generator requires.
- Counters: bit_cnt is $clog2(DATA_W+1) bits and gap_cnt is 8 bits; neither wraps within a frame.

Test Plan:
1. Reset, then accept 0xA5 in IDLE -> ser_active high 8 cycles starting 2 edges after accept; ser_data=1,0,1,0,0,1,0,1; then 8 low cycles; frame_done pulses once on the 8th low cycle; busy drops the following cycle.
2. Accept 0x3C, then present 0xFF during the 3rd SHIFT cycle -> 0xFF accepted immediately and in_ready=0 until the transfer edge. Output: 0,0,1,1,1,1,0,0, then 8 low cycles, then 1×8, then 8 low; exactly 8 gap cycles between frames.
3. Three bytes 0x01, 0x02, 0x03 offered continuously -> the third stalls (in_ready=0) until the second loads; all three frames are emitted in order with correct bits; in_data is held stable during the stall.
4. Reset asserted on the 4th SHIFT cycle of 0xF0 while hold holds 0x0F -> next cycle all outputs are at reset values; the held byte is never emitted; a new byte 0x81 afterwards emits normally.
5. LSB_FIRST=0, byte 0xA5 -> ser_data=1,0,1,0,0,1,0,1 MSB-first (bit7..bit0); with 0xC1 the sequence is 1,1,0,0,0,0,0,1.
6. GAP_CYCLES=10, two back-to-back bytes -> exactly 10 low cycles between frames; frame_done on the 10th low cycle of each frame.
